// File: rtl/main_memory_ctrl.sv
// Shared main-memory controller on the snoop bus: fixed-latency line fills and write-backs,
// yielding to cache-to-cache transfers on Mem_oprn_abort.
module main_memory_ctrl #(
    parameter int ADDRESSSIZE = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int RD_LAT      = 4,
    parameter int WR_LAT      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDRESSSIZE-1:0] Address_Com,
    inout  wire  [ADDRESSSIZE-1:0] Data_Bus_Com,
    input  logic                   BusRd,
    input  logic                   BusRdX,
    input  logic                   Mem_wr,
    input  logic                   Mem_oprn_abort,
    inout  wire                    Data_in_Bus,
    output logic                   Mem_write_done
);

    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_WAIT,
        WR_DONE
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [ADDRESSSIZE-1:0] wrData_q;
    logic [ADDRESSSIZE-1:0] rdData_q;
    logic [ADDRESSSIZE-1:0] rdData_d;
    logic                   drive_q;
    logic                   done_q;

    logic [ADDRESSSIZE-1:0] mem_q [MEM_DEPTH];
    // A word never written since time zero reads back as its own byte address.
    logic [MEM_DEPTH-1:0]   written_q = '0;

    logic [IDX_W-1:0] reqIdx;
    logic             readReq;
    logic             cntExpired;
    logic             memWe;
    logic             unusedAddrBits;

    assign reqIdx         = Address_Com[IDX_W+1:2];
    assign readReq        = BusRd | BusRdX;
    assign cntExpired     = (cnt_q == '0);
    assign memWe          = !rst && (state_q == WR_WAIT) && cntExpired && !Mem_oprn_abort;
    assign unusedAddrBits = ^{Address_Com[ADDRESSSIZE-1:IDX_W+2], Address_Com[1:0]};

    always_comb begin
        rdData_d = ADDRESSSIZE'({idx_q, 2'b00});
        if (written_q[idx_q]) begin
            rdData_d = mem_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem_q[idx_q]     <= wrData_q;
            written_q[idx_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Write-backs win so a fill never sees stale data for the same line.
                    if (Mem_wr) begin
                        idx_q    <= reqIdx;
                        wrData_q <= Data_Bus_Com;
                        cnt_q    <= WR_LOAD;
                        state_q  <= WR_WAIT;
                    end else if (readReq) begin
                        idx_q   <= reqIdx;
                        cnt_q   <= RD_LOAD;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (Mem_oprn_abort) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cntExpired) begin
                        rdData_q <= rdData_d;
                        drive_q  <= 1'b1;
                        state_q  <= RD_DRIVE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RD_DRIVE: begin
                    if (Mem_oprn_abort || !readReq) begin
                        drive_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (Mem_oprn_abort) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cntExpired) begin
                        done_q  <= 1'b1;
                        state_q <= WR_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WR_DONE: begin
                    if (!Mem_wr) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    drive_q <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Data_Bus_Com   = drive_q ? rdData_q : 'z;
    assign Data_in_Bus    = drive_q ? 1'b1 : 1'bz;
    assign Mem_write_done = done_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench for main_memory_ctrl: expected read data is queued when a read is issued
// and popped when the controller drives the bus.
module tb_main_memory_ctrl;

    localparam int AW      = 32;
    localparam int DEPTH   = 1024;
    localparam int RDL     = 4;
    localparam int WRL     = 2;
    localparam int TIMEOUT = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic          busRd;
    logic          busRdX;
    logic          memWr;
    logic          abort;
    logic          tbDrive;
    logic [AW-1:0] tbData;
    wire  [AW-1:0] dataBus;
    wire           dataInBus;
    logic          memWriteDone;

    int            vecCount  = 0;
    int            missCount = 0;
    logic [AW-1:0] expQ[$];
    logic [AW-1:0] memModel [DEPTH];

    always #5 clk = ~clk;

    assign dataBus = tbDrive ? tbData : 'z;

    main_memory_ctrl #(
        .ADDRESSSIZE(AW),
        .MEM_DEPTH  (DEPTH),
        .RD_LAT     (RDL),
        .WR_LAT     (WRL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Address_Com   (addr),
        .Data_Bus_Com  (dataBus),
        .BusRd         (busRd),
        .BusRdX        (busRdX),
        .Mem_wr        (memWr),
        .Mem_oprn_abort(abort),
        .Data_in_Bus   (dataInBus),
        .Mem_write_done(memWriteDone)
    );

    task automatic issueRead(input logic [AW-1:0] a, input bit useRdX);
        addr   = a;
        busRd  = !useRdX;
        busRdX = useRdX;
    endtask

    task automatic issueWrite(input logic [AW-1:0] a, input logic [AW-1:0] d);
        addr    = a;
        memWr   = 1'b1;
        tbDrive = 1'b1;
        tbData  = d;
    endtask

    task automatic endRead();
        busRd  = 1'b0;
        busRdX = 1'b0;
        @(negedge clk);
    endtask

    task automatic finishWrite();
        memWr   = 1'b0;
        tbDrive = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitReadData(output int cycles);
        cycles = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (dataInBus === 1'b1 || cycles >= TIMEOUT) break;
        end
    endtask

    task automatic waitWriteDone(output int cycles);
        cycles = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (memWriteDone === 1'b1 || cycles >= TIMEOUT) break;
        end
    endtask

    task automatic popExpected(output logic [AW-1:0] e);
        if (expQ.size() > 0) e = expQ.pop_front();
        else e = 'x;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            addr    = $urandom;
            busRd   = 1'($urandom_range(0, 1));
            busRdX  = 1'($urandom_range(0, 1));
            memWr   = 1'($urandom_range(0, 1));
            abort   = 1'($urandom_range(0, 1));
            tbDrive = memWr;
            tbData  = $urandom;
        end
        @(negedge clk);
        vecCount++;
        if (dataInBus === 1'b1) begin
            missCount++;
            $display("[TB] FAIL reset_data_in_bus: got %b, required released", dataInBus);
        end
        vecCount++;
        if (!$isunknown(dataBus) && dataBus !== '0) begin
            missCount++;
            $display("[TB] FAIL reset_data_bus: got %h, required released", dataBus);
        end
        vecCount++;
        if (memWriteDone !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_write_done: got %b, required 0", memWriteDone);
        end
        rst = 1'b0; busRd = 1'b0; busRdX = 1'b0; memWr = 1'b0; abort = 1'b0; tbDrive = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        int            cyc;
        logic [AW-1:0] e;
        expQ.push_back(32'h00000EEC);
        issueRead(32'hDEADBEEF, 1'b0);
        waitReadData(cyc);
        vecCount++;
        if (cyc !== RDL + 1) begin
            missCount++;
            $display("[TB] FAIL read_miss_latency: got %0d cycles, required %0d", cyc, RDL + 1);
        end
        popExpected(e);
        vecCount++;
        if (dataBus !== e) begin
            missCount++;
            $display("[TB] FAIL read_miss_data: got %h, required %h", dataBus, e);
        end
        repeat (2) begin
            @(negedge clk);
            vecCount++;
            if (dataInBus !== 1'b1 || dataBus !== e) begin
                missCount++;
                $display("[TB] FAIL read_miss_hold: got %b/%h, required 1/%h", dataInBus, dataBus, e);
            end
        end
        endRead();
        vecCount++;
        if (dataInBus === 1'b1 || (!$isunknown(dataBus) && dataBus !== '0)) begin
            missCount++;
            $display("[TB] FAIL read_miss_release: got %b/%h, required released", dataInBus, dataBus);
        end
    endtask

    task automatic test_write_then_read();
        int            cyc;
        logic [AW-1:0] e;
        issueWrite(32'h0, 32'h12345678);
        waitWriteDone(cyc);
        vecCount++;
        if (cyc !== WRL + 1) begin
            missCount++;
            $display("[TB] FAIL write_latency: got %0d cycles, required %0d", cyc, WRL + 1);
        end
        @(negedge clk);
        vecCount++;
        if (memWriteDone !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL write_done_hold: got %b, required 1", memWriteDone);
        end
        finishWrite();
        memModel[0] = 32'h12345678;
        vecCount++;
        if (memWriteDone !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL write_done_clear: got %b, required 0", memWriteDone);
        end
        expQ.push_back(32'h12345678);
        issueRead(32'h0, 1'b0);
        waitReadData(cyc);
        vecCount++;
        if (cyc !== RDL + 1) begin
            missCount++;
            $display("[TB] FAIL wr_rd_latency: got %0d cycles, required %0d", cyc, RDL + 1);
        end
        popExpected(e);
        vecCount++;
        if (dataBus !== e) begin
            missCount++;
            $display("[TB] FAIL wr_rd_data: got %h, required %h", dataBus, e);
        end
        endRead();
    endtask

    task automatic test_abort();
        int            cyc;
        logic [AW-1:0] e;
        bit            seen;
        issueRead(32'h40, 1'b1);
        @(negedge clk);
        @(negedge clk);
        abort  = 1'b1;
        busRdX = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        seen  = (dataInBus === 1'b1);
        repeat (RDL + 3) begin
            @(negedge clk);
            if (dataInBus === 1'b1 || (!$isunknown(dataBus) && dataBus !== '0)) seen = 1'b1;
        end
        vecCount++;
        if (seen) begin
            missCount++;
            $display("[TB] FAIL abort_read_drive: got driven=1, required driven=0");
        end
        expQ.push_back(memModel[16]);
        issueRead(32'h40, 1'b0);
        waitReadData(cyc);
        vecCount++;
        if (cyc !== RDL + 1) begin
            missCount++;
            $display("[TB] FAIL abort_reread_latency: got %0d cycles, required %0d", cyc, RDL + 1);
        end
        popExpected(e);
        vecCount++;
        if (dataBus !== e) begin
            missCount++;
            $display("[TB] FAIL abort_reread_data: got %h, required %h", dataBus, e);
        end
        endRead();

        issueWrite(32'h80, 32'hBAD0BAD0);
        @(negedge clk);
        abort   = 1'b1;
        memWr   = 1'b0;
        tbDrive = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        seen  = (memWriteDone === 1'b1);
        repeat (4) begin
            @(negedge clk);
            if (memWriteDone === 1'b1) seen = 1'b1;
        end
        vecCount++;
        if (seen) begin
            missCount++;
            $display("[TB] FAIL abort_write_done: got done=1, required done=0");
        end
        expQ.push_back(memModel[32]);
        issueRead(32'h80, 1'b1);
        waitReadData(cyc);
        popExpected(e);
        vecCount++;
        if (dataBus !== e) begin
            missCount++;
            $display("[TB] FAIL abort_write_data: got %h, required %h", dataBus, e);
        end
        endRead();
    endtask

    task automatic test_simultaneous();
        int            cyc;
        logic [AW-1:0] e;
        issueWrite(32'h10, 32'hCAFEF00D);
        busRdX = 1'b1;
        waitWriteDone(cyc);
        vecCount++;
        if (cyc !== WRL + 1 || dataInBus === 1'b1) begin
            missCount++;
            $display("[TB] FAIL simul_write_first: got %0d cycles drive=%b, required %0d drive=0",
                     cyc, dataInBus, WRL + 1);
        end
        memModel[4] = 32'hCAFEF00D;
        expQ.push_back(32'hCAFEF00D);
        memWr   = 1'b0;
        tbDrive = 1'b0;
        waitReadData(cyc);
        vecCount++;
        if (cyc !== RDL + 2) begin
            missCount++;
            $display("[TB] FAIL simul_read_latency: got %0d cycles, required %0d", cyc, RDL + 2);
        end
        popExpected(e);
        vecCount++;
        if (dataBus !== e) begin
            missCount++;
            $display("[TB] FAIL simul_read_data: got %h, required %h", dataBus, e);
        end
        endRead();
    endtask

    task automatic test_reset_mid_op();
        int            cyc;
        logic [AW-1:0] e;
        expQ.push_back(memModel[64]);
        issueRead(32'h100, 1'b0);
        waitReadData(cyc);
        popExpected(e);
        vecCount++;
        if (dataBus !== e) begin
            missCount++;
            $display("[TB] FAIL rst_read_data: got %h, required %h", dataBus, e);
        end
        rst = 1'b1;
        @(negedge clk);
        vecCount++;
        if (dataInBus === 1'b1 || (!$isunknown(dataBus) && dataBus !== '0)) begin
            missCount++;
            $display("[TB] FAIL rst_mid_read_release: got %b/%h, required released", dataInBus, dataBus);
        end
        rst   = 1'b0;
        busRd = 1'b0;
        @(negedge clk);

        issueWrite(32'h20, 32'h55AA55AA);
        @(negedge clk);
        rst     = 1'b1;
        memWr   = 1'b0;
        tbDrive = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expQ.push_back(memModel[8]);
        issueRead(32'h20, 1'b0);
        waitReadData(cyc);
        vecCount++;
        if (cyc !== RDL + 1) begin
            missCount++;
            $display("[TB] FAIL rst_after_latency: got %0d cycles, required %0d", cyc, RDL + 1);
        end
        popExpected(e);
        vecCount++;
        if (dataBus !== e) begin
            missCount++;
            $display("[TB] FAIL rst_dropped_write: got %h, required %h", dataBus, e);
        end
        endRead();
        expQ.push_back(memModel[0]);
        issueRead(32'h0, 1'b1);
        waitReadData(cyc);
        popExpected(e);
        vecCount++;
        if (dataBus !== e) begin
            missCount++;
            $display("[TB] FAIL rst_kept_write: got %h, required %h", dataBus, e);
        end
        endRead();
    endtask

    task automatic test_back_to_back();
        int            cyc;
        int            idx;
        logic [AW-1:0] a;
        logic [AW-1:0] d;
        logic [AW-1:0] e;
        for (int n = 0; n < 10; n++) begin
            idx = $urandom_range(0, 63);
            a   = AW'(($urandom_range(0, 15) << 12) | (idx << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                issueWrite(a, d);
                waitWriteDone(cyc);
                vecCount++;
                if (cyc !== WRL + 1) begin
                    missCount++;
                    $display("[TB] FAIL b2b_write_latency: got %0d cycles, required %0d", cyc, WRL + 1);
                end
                finishWrite();
                memModel[idx] = d;
            end else begin
                expQ.push_back(memModel[idx]);
                issueRead(a, 1'($urandom_range(0, 1)));
                waitReadData(cyc);
                popExpected(e);
                vecCount++;
                if (cyc !== RDL + 1 || dataBus !== e) begin
                    missCount++;
                    $display("[TB] FAIL b2b_read: got %0d cycles data %h, required %0d cycles data %h",
                             cyc, dataBus, RDL + 1, e);
                end
                endRead();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) memModel[i] = AW'(i << 2);
        rst = 1'b1; addr = '0; busRd = 1'b0; busRdX = 1'b0; memWr = 1'b0;
        abort = 1'b0; tbDrive = 1'b0; tbData = '0;
        test_reset();
        test_read_miss();
        test_write_then_read();
        test_abort();
        test_simultaneous();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
